// File: rtl/sampler_pkg.sv
// Shared types and LFSR helpers for the rejection sampler controller.
// The step function is reused by the bench reference model.
package sampler_pkg;

  localparam int LFSR_W = 64;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    CHECK,
    EMIT,
    DONE,
    FAIL
  } state_t;

  // Galois form, right-shifting: the bit falling off the bottom folds into the taps.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/sampler_lfsr64.sv
// 64-bit Galois LFSR with seed load and step enable.
// An all-zero seed would lock the register, so it loads as 1 instead.
module sampler_lfsr64
  import sampler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr_next
);

  logic [LFSR_W-1:0] value;

  assign lfsr_next = lfsr_step(value);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= {{(LFSR_W-1){1'b0}}, 1'b1};
    end else if (load) begin
      value <= (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      value <= lfsr_next;
    end
  end

endmodule

// File: rtl/rejection_sampler_ctrl.sv
// Rejection sampler: fills a candidate from the LFSR, checks it against an
// external combinational checker, and streams satisfying candidates out.
module rejection_sampler_ctrl
  import sampler_pkg::*;
#(
  parameter int VEC_W     = 1024,
  parameter int MAX_TRIES = 1024,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [63:0]       seed,
  input  logic [CNT_W-1:0]  num_samples,
  output logic [VEC_W-1:0]  cand,
  input  logic              sat,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [VEC_W-1:0]  sample_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  accepted,
  output logic [31:0]       total_tries
);

  localparam int WORDS = VEC_W / LFSR_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  state_t             state;
  logic [IDX_W-1:0]   fill_idx;
  logic [TRY_W-1:0]   try_cnt;
  logic [TRY_W-1:0]   try_next;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   accepted_next;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [VEC_W-1:0]   cand_shift;
  logic               lfsr_load;
  logic               lfsr_step_en;

  assign lfsr_load     = (state == IDLE) && start;
  assign lfsr_step_en  = (state == GEN);
  assign try_next      = try_cnt + TRY_W'(1);
  assign accepted_next = accepted + CNT_W'(1);
  assign sample_data   = cand;

  sampler_lfsr64 u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lfsr_load),
    .step      (lfsr_step_en),
    .seed      (seed),
    .lfsr_next (lfsr_next)
  );

  // New LFSR words enter at the bottom, so the first word ends up in the top slice.
  generate
    if (WORDS == 1) begin : g_single
      assign cand_shift = lfsr_next;
    end else begin : g_multi
      assign cand_shift = {cand[VEC_W-LFSR_W-1:0], lfsr_next};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cand         <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      accepted     <= '0;
      total_tries  <= '0;
      fill_idx     <= '0;
      try_cnt      <= '0;
      target       <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            target      <= num_samples;
            accepted    <= '0;
            total_tries <= '0;
            try_cnt     <= '0;
            fill_idx    <= '0;
            busy        <= 1'b1;
            if (num_samples == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end
        GEN: begin
          cand <= cand_shift;
          if (fill_idx == IDX_W'(WORDS - 1)) begin
            fill_idx <= '0;
            state    <= CHECK;
          end else begin
            fill_idx <= fill_idx + IDX_W'(1);
          end
        end
        CHECK: begin
          try_cnt <= try_next;
          if (total_tries != '1) begin
            total_tries <= total_tries + 32'd1;
          end
          if (sat) begin
            state        <= EMIT;
            sample_valid <= 1'b1;
          end else if (try_next == TRY_W'(MAX_TRIES)) begin
            state <= FAIL;
            fail  <= 1'b1;
          end else begin
            state <= GEN;
          end
        end
        // cand is frozen here until the sink takes it.
        EMIT: begin
          if (sample_ready) begin
            sample_valid <= 1'b0;
            accepted     <= accepted_next;
            try_cnt      <= '0;
            if (accepted_next == target) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end
        DONE, FAIL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rejection_sampler_ctrl.sv
// Directed bench for rejection_sampler_ctrl with VEC_W=128, MAX_TRIES=4 and
// a bench-selected checker stub (always true, always false, or cand[0]).
module tb_rejection_sampler_ctrl;
  import sampler_pkg::*;

  localparam int VEC_W     = 128;
  localparam int MAX_TRIES = 4;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [63:0]       seed;
  logic [CNT_W-1:0]  num_samples;
  logic [VEC_W-1:0]  cand;
  logic              sat;
  logic              sample_valid;
  logic              sample_ready;
  logic [VEC_W-1:0]  sample_data;
  logic              busy;
  logic              done;
  logic              fail;
  logic [CNT_W-1:0]  accepted;
  logic [31:0]       total_tries;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  assign sat = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : cand[0];

  always #5 clk = ~clk;

  rejection_sampler_ctrl #(
    .VEC_W     (VEC_W),
    .MAX_TRIES (MAX_TRIES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .num_samples  (num_samples),
    .cand         (cand),
    .sat          (sat),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .accepted     (accepted),
    .total_tries  (total_tries)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two LFSR steps per candidate; the first word lands in the upper half.
  task automatic model_cand(inout logic [63:0] m, output logic [VEC_W-1:0] c);
    m = lfsr_step(m);
    c[127:64] = m;
    m = lfsr_step(m);
    c[63:0] = m;
  endtask

  task automatic do_start(input logic [63:0] s, input logic [CNT_W-1:0] n);
    seed = s;
    num_samples = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, sample_valid, done, fail} !== 4'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=0000", {busy, sample_valid, done, fail});
    end
    total++;
    if (cand !== '0) begin
      bad++;
      $display("[TB] FAIL reset_cand got=%h want=0", cand);
    end
    total++;
    if (accepted !== '0 || total_tries !== '0) begin
      bad++;
      $display("[TB] FAIL reset_counts got=%0d/%0d want=0/0", accepted, total_tries);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0]      m;
    logic [VEC_W-1:0] exp;
    int nvalid;
    int ndone;
    m = 64'h1;
    nvalid = 0;
    ndone = 0;
    mode = 0;
    sample_ready = 1'b1;
    do_start(64'h1, 3);
    for (int k = 0; k < 20; k++) begin
      if (sample_valid) begin
        model_cand(m, exp);
        total++;
        if (sample_data !== exp) begin
          bad++;
          $display("[TB] FAIL basic_data got=%h want=%h", sample_data, exp);
        end
        total++;
        if (k != 3 + 4 * nvalid) begin
          bad++;
          $display("[TB] FAIL basic_valid_cycle got=%0d want=%0d", k, 3 + 4 * nvalid);
        end
        nvalid++;
      end
      if (done) begin
        ndone++;
        total++;
        if (k != 12) begin
          bad++;
          $display("[TB] FAIL basic_done_cycle got=%0d want=12", k);
        end
      end
      tick();
    end
    total++;
    if (nvalid != 3 || ndone != 1) begin
      bad++;
      $display("[TB] FAIL basic_counts got valid=%0d done=%0d want 3/1", nvalid, ndone);
    end
    total++;
    if (accepted !== 16'd3 || total_tries !== 32'd3 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL basic_final got acc=%0d tries=%0d busy=%b want 3/3/0",
               accepted, total_tries, busy);
    end
  endtask

  task automatic test_fail();
    int nvalid;
    int nfail;
    int ndone;
    nvalid = 0;
    nfail = 0;
    ndone = 0;
    mode = 1;
    sample_ready = 1'b1;
    do_start(64'h1234, 2);
    for (int k = 0; k < 20; k++) begin
      if (sample_valid) nvalid++;
      if (done) ndone++;
      if (fail) begin
        nfail++;
        total++;
        if (k != 12) begin
          bad++;
          $display("[TB] FAIL fail_cycle got=%0d want=12", k);
        end
      end
      tick();
    end
    total++;
    if (nvalid != 0 || nfail != 1 || ndone != 0) begin
      bad++;
      $display("[TB] FAIL fail_pulses got valid=%0d fail=%0d done=%0d want 0/1/0",
               nvalid, nfail, ndone);
    end
    total++;
    if (accepted !== 16'd0 || total_tries !== 32'd4) begin
      bad++;
      $display("[TB] FAIL fail_final got acc=%0d tries=%0d want 0/4", accepted, total_tries);
    end
  endtask

  task automatic test_random_ready();
    logic [63:0]      m;
    logic [VEC_W-1:0] c;
    logic [VEC_W-1:0] exp_q[$];
    logic [VEC_W-1:0] exp;
    logic [VEC_W-1:0] prev_data;
    logic             prev_valid;
    logic             prev_ready;
    logic             exp_fail;
    logic             ended;
    int tries;
    int exp_total;
    int exp_acc;
    int ndone;
    int nfail;
    m = 64'hACE1_2345_6789_BEEF;
    exp_fail = 1'b0;
    exp_total = 0;
    for (int s = 0; s < 200 && !exp_fail; s++) begin
      tries = 0;
      do begin
        model_cand(m, c);
        tries++;
        exp_total++;
      end while (!c[0] && tries < MAX_TRIES);
      if (c[0]) exp_q.push_back(c);
      else exp_fail = 1'b1;
    end
    exp_acc = exp_q.size();
    mode = 2;
    ndone = 0;
    nfail = 0;
    ended = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data = '0;
    do_start(64'hACE1_2345_6789_BEEF, 200);
    for (int k = 0; k < 20000 && !ended; k++) begin
      if (done || fail) begin
        ended = 1'b1;
        if (done) ndone++;
        if (fail) nfail++;
      end else begin
        sample_ready = 1'($urandom_range(0, 1));
        if (prev_valid && !prev_ready) begin
          total++;
          if (!sample_valid || sample_data !== prev_data) begin
            bad++;
            $display("[TB] FAIL rr_stable got v=%b d=%h want v=1 d=%h",
                     sample_valid, sample_data, prev_data);
          end
        end
        if (sample_valid && sample_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL rr_extra got=%h want=none", sample_data);
          end else begin
            exp = exp_q.pop_front();
            if (sample_data !== exp) begin
              bad++;
              $display("[TB] FAIL rr_data got=%h want=%h", sample_data, exp);
            end
          end
          total++;
          if (sample_data[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rr_bit0 got=%b want=1", sample_data[0]);
          end
        end
        prev_valid = sample_valid;
        prev_ready = sample_ready;
        prev_data = sample_data;
      end
      tick();
    end
    sample_ready = 1'b1;
    total++;
    if (!ended) begin
      bad++;
      $display("[TB] FAIL rr_timeout got=running want=finished");
    end
    total++;
    if (ndone != (exp_fail ? 0 : 1) || nfail != (exp_fail ? 1 : 0)) begin
      bad++;
      $display("[TB] FAIL rr_outcome got done=%0d fail=%0d want fail=%b", ndone, nfail, exp_fail);
    end
    total++;
    if (accepted !== CNT_W'(exp_acc) || total_tries !== 32'(exp_total) || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rr_counts got acc=%0d tries=%0d left=%0d want %0d/%0d/0",
               accepted, total_tries, exp_q.size(), exp_acc, exp_total);
    end
    tick();
    tick();
  endtask

  task automatic test_seed_zero_and_empty();
    int nvalid;
    nvalid = 0;
    mode = 0;
    sample_ready = 1'b1;
    do_start(64'h0, 1);
    for (int k = 0; k < 10; k++) begin
      if (sample_valid) begin
        nvalid++;
        total++;
        if (k != 3 || sample_data[127:64] !== 64'hD800_0000_0000_0000 ||
            sample_data[63:0] !== 64'h6C00_0000_0000_0000) begin
          bad++;
          $display("[TB] FAIL seed0_data got k=%0d d=%h want k=3 d=d800..6c00..", k, sample_data);
        end
      end
      tick();
    end
    total++;
    if (nvalid != 1 || accepted !== 16'd1) begin
      bad++;
      $display("[TB] FAIL seed0_count got valid=%0d acc=%0d want 1/1", nvalid, accepted);
    end
    do_start(64'h5, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL empty_first got done=%b busy=%b want 1/1", done, busy);
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL empty_second got done=%b busy=%b valid=%b want 0/0/0",
               done, busy, sample_valid);
    end
  endtask

  task automatic test_reset_midrun();
    int npulse;
    int waited;
    mode = 0;
    sample_ready = 1'b1;
    do_start(64'h1, 3);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({busy, sample_valid, done, fail} !== 4'b0 || cand !== '0 ||
        accepted !== '0 || total_tries !== '0) begin
      bad++;
      $display("[TB] FAIL rst_gen got flags=%b cand=%h acc=%0d tries=%0d want all 0",
               {busy, sample_valid, done, fail}, cand, accepted, total_tries);
    end
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || fail || busy) npulse++;
      tick();
    end
    total++;
    if (npulse != 0) begin
      bad++;
      $display("[TB] FAIL rst_gen_after got=%0d want=0", npulse);
    end
    sample_ready = 1'b0;
    do_start(64'h1, 3);
    waited = 0;
    while (!sample_valid && waited < 10) begin
      tick();
      waited++;
    end
    total++;
    if (!sample_valid) begin
      bad++;
      $display("[TB] FAIL rst_emit_wait got valid=0 want 1");
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({busy, sample_valid, done, fail} !== 4'b0 || cand !== '0 ||
        accepted !== '0 || total_tries !== '0) begin
      bad++;
      $display("[TB] FAIL rst_emit got flags=%b cand=%h acc=%0d tries=%0d want all 0",
               {busy, sample_valid, done, fail}, cand, accepted, total_tries);
    end
    npulse = 0;
    for (int k = 0; k < 8; k++) begin
      if (done || fail || busy) npulse++;
      tick();
    end
    total++;
    if (npulse != 0) begin
      bad++;
      $display("[TB] FAIL rst_emit_after got=%0d want=0", npulse);
    end
    sample_ready = 1'b1;
  endtask

  task automatic test_start_ignored();
    logic [63:0]      m;
    logic [VEC_W-1:0] cur;
    int nv;
    int ndone;
    int waited;
    m = 64'h0F0F;
    mode = 0;
    sample_ready = 1'b0;
    do_start(64'h0F0F, 2);
    waited = 0;
    while (!sample_valid && waited < 10) begin
      tick();
      waited++;
    end
    model_cand(m, cur);
    seed = 64'h5555;
    num_samples = 7;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (sample_valid !== 1'b1 || sample_data !== cur) begin
      bad++;
      $display("[TB] FAIL ign_hold got v=%b d=%h want v=1 d=%h", sample_valid, sample_data, cur);
    end
    sample_ready = 1'b1;
    nv = 0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (sample_valid) begin
        if (nv > 0) model_cand(m, cur);
        total++;
        if (sample_data !== cur) begin
          bad++;
          $display("[TB] FAIL ign_data got=%h want=%h", sample_data, cur);
        end
        nv++;
      end
      if (done) ndone++;
      tick();
    end
    total++;
    if (nv != 2 || ndone != 1 || accepted !== 16'd2) begin
      bad++;
      $display("[TB] FAIL ign_counts got valid=%0d done=%0d acc=%0d want 2/1/2",
               nv, ndone, accepted);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    seed = '0;
    num_samples = '0;
    sample_ready = 1'b0;
    test_reset();
    test_basic();
    test_fail();
    test_random_ready();
    test_seed_zero_and_empty();
    test_reset_midrun();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
